sobel_window_stage: RTL and testbench

SOBEL_WINDOW_STAGE -- requirements
Module: sobel_window_stage

---
 rtl/sobel_window_stage_if.sv | 25 ++
 rtl/sobel_window_stage.sv | 98 +++++++++
 tb/tb_sobel_window_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_stage_if.sv
// Window-in / edge-pixel-out bundle for the Sobel stage; master is the upstream
// window source (also drives stall), slave is the Sobel stage itself.
interface sobel_window_stage_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 14
);
   logic [DATA_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic              win_valid;
   logic              win_last;
   logic              stall;
   logic [DATA_W-1:0] edge_pix;
   logic              edge_valid;
   logic              frame_done;
   logic [CNT_W-1:0]  pix_count;

   modport master (
      output p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, win_last, stall,
      input  edge_pix, edge_valid, frame_done, pix_count
   );

   modport slave (
      input  p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, win_last, stall,
      output edge_pix, edge_valid, frame_done, pix_count
   );
endinterface

// File: rtl/sobel_window_stage.sv
// Sobel gradient magnitude |Gx|+|Gy| on a 3x3 window; SOBEL_THRESH_EN binarises against THRESH.
// Latency 3 cycles, one window per cycle.
// stall=1 freezes every register including outputs; inputs are not sampled while stalled.
module sobel_window_stage #(
   parameter int                DATA_W = 8,
   parameter int                CNT_W  = 14,
   parameter logic [DATA_W-1:0] THRESH = DATA_W'(64)
)(
   input  logic                  clk,
   input  logic                  rst,
   sobel_window_stage_if.slave   io
);
   localparam int W = DATA_W + 3;

   function automatic logic [W-1:0] ext(input logic [DATA_W-1:0] p);
      return {3'b000, p};
   endfunction

   logic [W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [W-1:0] gx_nxt, gy_nxt;
   logic signed [W-1:0] s1_gx, s1_gy;
   logic                v1, l1;

   logic [W-1:0]        abs_gx, abs_gy, m_nxt;
   logic [W-1:0]        s2_m;
   logic                v2, l2;

   logic [DATA_W-1:0]   pix_nxt;
   logic [CNT_W-1:0]    cnt_inc;
   logic                frame_closed;

   // Stage 1: operands are zero-extended so the signed difference never overflows.
   always_comb begin
      gx_pos = ext(io.p3) + (ext(io.p6) << 1) + ext(io.p9);
      gx_neg = ext(io.p1) + (ext(io.p4) << 1) + ext(io.p7);
      gy_pos = ext(io.p7) + (ext(io.p8) << 1) + ext(io.p9);
      gy_neg = ext(io.p1) + (ext(io.p2) << 1) + ext(io.p3);
      gx_nxt = signed'(gx_pos - gx_neg);
      gy_nxt = signed'(gy_pos - gy_neg);
   end

   always_comb begin
      abs_gx = s1_gx[W-1] ? W'(-s1_gx) : W'(s1_gx);
      abs_gy = s1_gy[W-1] ? W'(-s1_gy) : W'(s1_gy);
      m_nxt  = abs_gx + abs_gy;
   end

`ifdef SOBEL_THRESH_EN
   always_comb begin
      pix_nxt = (s2_m >= W'(THRESH)) ? '1 : '0;
   end
`else
   logic unused_thresh;
   assign unused_thresh = ^THRESH;

   always_comb begin
      pix_nxt = (|s2_m[W-1:DATA_W]) ? '1 : s2_m[DATA_W-1:0];
   end
`endif

   always_comb begin
      cnt_inc = (io.pix_count == '1) ? io.pix_count : io.pix_count + CNT_W'(1);
   end

   // frame_closed remembers that the last counted pixel ended a frame, so the
   // next counted pixel restarts at 1 even across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_gx         <= '0;
         s1_gy         <= '0;
         v1            <= 1'b0;
         l1            <= 1'b0;
         s2_m          <= '0;
         v2            <= 1'b0;
         l2            <= 1'b0;
         io.edge_pix   <= '0;
         io.edge_valid <= 1'b0;
         io.frame_done <= 1'b0;
         io.pix_count  <= '0;
         frame_closed  <= 1'b0;
      end else if (!io.stall) begin
         s1_gx         <= gx_nxt;
         s1_gy         <= gy_nxt;
         v1            <= io.win_valid;
         l1            <= io.win_valid & io.win_last;
         s2_m          <= m_nxt;
         v2            <= v1;
         l2            <= l1;
         io.edge_pix   <= pix_nxt;
         io.edge_valid <= v2;
         io.frame_done <= v2 & l2;
         if (v2) begin
            io.pix_count <= frame_closed ? CNT_W'(1) : cnt_inc;
            frame_closed <= l2;
         end
      end
   end
endmodule

// File: tb/tb_sobel_window_stage.sv
// Directed bench for sobel_window_stage: latency, magnitude/saturation, stall, framing, reset.
module tb_sobel_window_stage;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   sobel_window_stage_if #(.DATA_W(8), .CNT_W(14)) bus ();

   sobel_window_stage #(.DATA_W(8), .CNT_W(14), .THRESH(8'd64)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, b, c, d, e, f, g, h, i,
                        input logic v, input logic l);
      bus.p1 = a; bus.p2 = b; bus.p3 = c;
      bus.p4 = d; bus.p5 = e; bus.p6 = f;
      bus.p7 = g; bus.p8 = h; bus.p9 = i;
      bus.win_valid = v;
      bus.win_last  = l;
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   // Expected pixel for a hand-computed magnitude m in the active build.
   function automatic logic [7:0] pix_of(input int m);
`ifdef SOBEL_THRESH_EN
      return (m >= 64) ? 8'hFF : 8'h00;
`else
      return (m > 255) ? 8'hFF : 8'(m);
`endif
   endfunction

   // One isolated window: no output after 2 edges, output exactly on the 3rd.
   task automatic single(input string tag, input logic [7:0] a, b, c, d, e, f, g, h, i,
                         input int m, input int cnt);
      drive(a, b, c, d, e, f, g, h, i, 1'b1, 1'b0);
      step();
      bubble();
      step();
      chk({tag, "_early"}, bus.edge_valid, 0);
      step();
      chk({tag, "_valid"}, bus.edge_valid, 1);
      chk({tag, "_pix"}, bus.edge_pix, pix_of(m));
      chk({tag, "_cnt"}, bus.pix_count, cnt);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      bus.stall   = 1'b0;
      bubble();
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", bus.edge_valid, 0);
      chk("rst_pix", bus.edge_pix, 0);
      chk("rst_done", bus.frame_done, 0);
      chk("rst_cnt", bus.pix_count, 0);

      // Magnitude, absolute value and saturation/threshold boundaries.
      single("flat",  7, 7, 7, 7, 7, 7, 7, 7, 7,    0, 1);
      single("ramp",  0, 0, 10, 0, 0, 10, 0, 0, 10, 40, 2);
      single("max",   0, 0, 255, 0, 0, 255, 0, 0, 255, 1020, 3);
      single("gy",    0, 0, 0, 0, 0, 0, 20, 20, 20, 80, 4);
      single("neg",   100, 0, 0, 0, 0, 0, 0, 0, 0, 200, 5);
      single("m256",  0, 0, 0, 0, 0, 0, 0, 0, 128, 256, 6);
      single("m254",  0, 0, 0, 0, 0, 0, 0, 0, 127, 254, 7);
      single("m64",   0, 0, 0, 0, 0, 0, 0, 0, 32, 64, 8);
      single("m62",   0, 0, 0, 0, 0, 0, 0, 0, 31, 62, 9);
      step();
      chk("idle_valid", bus.edge_valid, 0);
      chk("idle_cnt", bus.pix_count, 9);

      // Reset with two windows in flight.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 50, 1'b1, 1'b0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 60, 1'b1, 1'b1);
      step();
      bubble();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", bus.edge_valid, 0);
      chk("mid_rst_pix", bus.edge_pix, 0);
      chk("mid_rst_cnt", bus.pix_count, 0);
      chk("mid_rst_done", bus.frame_done, 0);
      step();
      chk("flush1", bus.edge_valid, 0);
      step();
      chk("flush2", bus.edge_valid, 0);
      step();
      chk("flush3", bus.edge_valid, 0);
      chk("flush_done", bus.frame_done, 0);

      // Five-window frame (p9=10k -> M=20k) with a 2-cycle stall mid-stream.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 1'b1, 1'b0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 20, 1'b1, 1'b0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 30, 1'b1, 1'b0);
      step();
      chk("s1_pix", bus.edge_pix, pix_of(20));
      chk("s1_cnt", bus.pix_count, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 40, 1'b1, 1'b0);
      bus.stall = 1'b1;
      step();
      chk("stall1_valid", bus.edge_valid, 1);
      chk("stall1_pix", bus.edge_pix, pix_of(20));
      chk("stall1_cnt", bus.pix_count, 1);
      step();
      chk("stall2_pix", bus.edge_pix, pix_of(20));
      chk("stall2_cnt", bus.pix_count, 1);
      bus.stall = 1'b0;
      step();
      chk("s2_pix", bus.edge_pix, pix_of(40));
      chk("s2_cnt", bus.pix_count, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 50, 1'b1, 1'b1);
      step();
      chk("s3_pix", bus.edge_pix, pix_of(60));
      chk("s3_cnt", bus.pix_count, 3);
      bubble();
      step();
      chk("s4_pix", bus.edge_pix, pix_of(80));
      chk("s4_cnt", bus.pix_count, 4);
      chk("s4_done", bus.frame_done, 0);
      step();
      chk("s5_valid", bus.edge_valid, 1);
      chk("s5_pix", bus.edge_pix, pix_of(100));
      chk("s5_cnt", bus.pix_count, 5);
      chk("s5_done", bus.frame_done, 1);
      bus.stall = 1'b1;
      step();
      chk("done_hold", bus.frame_done, 1);
      chk("done_hold_cnt", bus.pix_count, 5);
      bus.stall = 1'b0;
      step();
      chk("after_valid", bus.edge_valid, 0);
      chk("after_done", bus.frame_done, 0);
      chk("after_cnt", bus.pix_count, 5);
      step();
      chk("between_cnt", bus.pix_count, 5);

      single("newframe", 0, 0, 0, 0, 0, 0, 0, 0, 5, 10, 1);
      chk("newframe_done", bus.frame_done, 0);

      // Alternating valid; win_last rides on the bubbles and must be ignored.
      for (int i = 0; i < 9; i++) begin
         if (i < 6 && (i % 2) == 0)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1, 1'b0);
         else
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 1'b1);
         step();
         if (i >= 2) begin
            chk($sformatf("alt_valid%0d", i - 2), bus.edge_valid,
                ((i - 2) < 6 && ((i - 2) % 2) == 0) ? 1 : 0);
            chk($sformatf("alt_done%0d", i - 2), bus.frame_done, 0);
         end
      end
      chk("alt_cnt", bus.pix_count, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
